mux_nx1_arb: RTL and testbench

Parametrised N-to-1 registered multiplexer, successor to the 2:1 registered mux. Each input channel has a valid/ready handshake. Two selection modes:
- fixed select via `sel`
- round-robin arbitration across valid channels

A single output register stage with valid/ready backpressure feeds downstream logic. The block sits between multiple producers and one shared consumer.

---
 rtl/mux_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 61 ++++++
 rtl/mux_nx1_arb.sv | 126 ++++++++++++
 tb/tb_mux_nx1_arb.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared types and helpers for the N-to-1 registered mux and
//                its round-robin arbiter.
//                  mux_mode_e : fixed-select / round-robin selection mode
//                  ch_slice   : base bit of channel `ch` in a flattened bus
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    // Channel ch of a flattened bus occupies [ch_slice(ch,width) +: width].
    function automatic int unsigned ch_slice(input int unsigned ch,
                                             input int unsigned width);
        return ch * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter, mask-based double
//                priority. Search starts at ptr+1 and wraps through ptr.
//  Ports       : req       [N_CH]  request vector
//                ptr       [SEL_W] index of the last granted channel
//                en                grant enable (grant forced to 0 when low)
//                grant     [N_CH]  one-hot grant (zero if none / !en)
//                grant_idx [SEL_W] index of the winning request
//                grant_vld         a grant is issued
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_vld
);

    logic [N_CH-1:0] w_mask;
    logic [N_CH-1:0] w_req_masked;
    logic [N_CH-1:0] w_pick_hi;
    logic [N_CH-1:0] w_pick_lo;
    logic [N_CH-1:0] w_grant_raw;

    // Mask keeps only the channels strictly above the last winner.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_mask
            assign w_mask[gi] = (SEL_W'(gi) > ptr);
        end
    endgenerate

    assign w_req_masked = req & w_mask;

    // x & -x isolates the lowest set bit. The masked search wins when it
    // finds anything; otherwise the unmasked search provides the wrap-around.
    assign w_pick_hi   = w_req_masked & (-w_req_masked);
    assign w_pick_lo   = req & (-req);
    assign w_grant_raw = (|w_req_masked) ? w_pick_hi : w_pick_lo;

    assign grant     = en ? w_grant_raw : '0;
    assign grant_vld = en && (|req);

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_grant_raw[i]) begin
                grant_idx = SEL_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_nx1_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mux_nx1_arb
//  Description : Parametrised N-to-1 registered multiplexer with per-channel
//                valid/ready and one output register stage. Channel choice is
//                either fixed (sel) or round-robin over valid channels.
//  Ports       : clk, rst           clock, synchronous active-high reset
//                mode               0 = fixed select, 1 = round-robin
//                sel       [SEL_W]  channel used in fixed mode
//                in_data   [N*W]    flattened channel data
//                in_valid  [N]      per-channel valid
//                in_ready  [N]      per-channel ready (one-hot or zero)
//                out_data  [W]      registered selected data
//                out_ch    [SEL_W]  registered source channel index
//                out_valid          output register holds data
//                out_ready          downstream accepts out_data
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_nx1_arb
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [SEL_W-1:0] c_PTR_RST = SEL_W'(N_CH - 1);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_ch;
    logic [SEL_W-1:0] r_rr_ptr;

    mux_mode_e        w_mode;
    logic             w_load;
    logic             w_en;
    logic [N_CH-1:0]  w_sel_onehot;
    logic [N_CH-1:0]  w_fix_grant;
    logic             w_fix_vld;
    logic [N_CH-1:0]  w_arb_grant;
    logic [SEL_W-1:0] w_arb_idx;
    logic             w_arb_vld;
    logic             w_xfer;
    logic [SEL_W-1:0] w_xfer_idx;
    logic [WIDTH-1:0] w_xfer_data;

    assign w_mode = mux_mode_e'(mode);

    // Output register can take new data when empty or being drained now.
    assign w_load = !r_out_valid || out_ready;
    assign w_en   = w_load && !rst;

    // Decoding sel against real channel numbers only means an out-of-range
    // sel (non-power-of-two N_CH) simply never matches, giving no grant.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_sel_dec
            assign w_sel_onehot[gi] = (sel == SEL_W'(gi));
        end
    endgenerate

    assign w_fix_grant = (w_en && (w_mode == MODE_FIXED)) ? (in_valid & w_sel_onehot) : '0;
    assign w_fix_vld   = |w_fix_grant;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (r_rr_ptr),
        .en        (w_en && (w_mode == MODE_RR)),
        .grant     (w_arb_grant),
        .grant_idx (w_arb_idx),
        .grant_vld (w_arb_vld)
    );

    assign in_ready   = (w_mode == MODE_RR) ? w_arb_grant : w_fix_grant;
    assign w_xfer     = (w_mode == MODE_RR) ? w_arb_vld   : w_fix_vld;
    assign w_xfer_idx = (w_mode == MODE_RR) ? w_arb_idx   : sel;

    // AND-OR data mux keyed by the one-hot ready vector.
    always_comb begin
        w_xfer_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_xfer_data = w_xfer_data
                        | (in_data[ch_slice(i, WIDTH) +: WIDTH] & {WIDTH{in_ready[i]}});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= c_PTR_RST;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_xfer_data;
            r_out_ch    <= w_xfer_idx;
            if (w_mode == MODE_RR) begin
                r_rr_ptr <= w_xfer_idx;
            end
        end else if (out_ready) begin
            // Drained with nothing to replace it; data/ch keep stale values.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule
`default_nettype wire

// File: tb/tb_mux_nx1_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_nx1_arb
//  Description : Self-checking bench for mux_nx1_arb (N_CH=4 main instance,
//                N_CH=3 instance for out-of-range select).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_nx1_arb;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state for the 4-channel instance
    bit         ref_ov;
    logic [7:0] ref_od;
    int         ref_oc;
    int         ref_ptr;

    mux_nx1_arb #(.N_CH(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    mux_nx1_arb #(.N_CH(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check in_ready against the rules, predict the output
    // register, clock, then check the registered outputs.
    task automatic step();
        int         g;
        bit         load;
        logic [3:0] exp_rdy;
        #1;
        load = !ref_ov || out_ready;
        g = -1;
        if (!rst && load) begin
            if (mode == 1'b0) begin
                if (in_valid[sel]) g = int'(sel);
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (ref_ptr + k) % 4;
                    if (in_valid[c]) begin
                        g = c;
                        break;
                    end
                end
            end
        end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
        if (rst) begin
            ref_ov = 1'b0; ref_od = 8'h00; ref_oc = 0; ref_ptr = 3;
        end else if (g >= 0) begin
            ref_ov = 1'b1;
            ref_od = in_data[g*8 +: 8];
            ref_oc = g;
            if (mode) ref_ptr = g;
        end else if (out_ready) begin
            ref_ov = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, ref_ov});
        chk("out_data", {24'd0, out_data}, {24'd0, ref_od});
        chk("out_ch", {30'd0, out_ch}, 32'(ref_oc));
    endtask

    initial begin
        ref_ov = 1'b0; ref_od = 8'h00; ref_oc = 0; ref_ptr = 3;
        rst = 1'b1; mode = 1'b1; sel = 2'd0; in_data = 32'h44332211;
        in_valid = 4'b1111; out_ready = 1'b1;
        mode3 = 1'b0; sel3 = 2'd3; in_data3 = 24'hC2B1A0; in_valid3 = 3'b111; out_ready3 = 1'b1;

        // Reset held two cycles with everything valid
        step();
        step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        #1;
        chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
        rst = 1'b0;

        // First round-robin grant after reset is channel 0
        step();
        chk("first_rr_ch", {30'd0, out_ch}, 32'd0);

        // Fixed mode, sel=2
        mode = 1'b0; sel = 2'd2; in_data = 32'h11A52233;
        #1;
        chk("fixed_in_ready", {28'd0, in_ready}, 32'b0100);
        step();
        chk("fixed_data", {24'd0, out_data}, 32'hA5);
        chk("fixed_ch", {30'd0, out_ch}, 32'd2);

        // Round-robin, all valid: pointer still at 0 so 1,2,3,0,1,2
        mode = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            in_data = $urandom;
            step();
        end
        // Sparse 1010
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            in_data = $urandom;
            step();
        end

        // Backpressure with 0x3C held
        in_valid = 4'b1111; in_data = 32'h3C3C3C3C;
        step();
        out_ready = 1'b0; in_data = 32'h55667788;
        for (int i = 0; i < 3; i++) step();
        chk("bp_hold_data", {24'd0, out_data}, 32'h3C);
        out_ready = 1'b1;
        step();

        // Empty inputs: output drains
        in_valid = 4'b0000;
        step();
        step();
        chk("empty_drained", {31'd0, out_valid}, 32'd0);

        // Out-of-range sel on the 3-channel instance
        chk("oor_in_ready3", {29'd0, in_ready3}, 32'd0);
        chk("oor_out_valid3", {31'd0, out_valid3}, 32'd0);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            rst       = ($urandom_range(0, 39) == 0);
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0;

        // Reset mid-burst with output stalled
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        step();
        chk("midrst_restart_ch", {30'd0, out_ch}, 32'd0);
        step();

        // In-range sel on the 3-channel instance
        sel3 = 2'd1;
        #1;
        chk("sel1_in_ready3", {29'd0, in_ready3}, 32'b010);
        @(posedge clk);
        #1;
        chk("sel1_out_valid3", {31'd0, out_valid3}, 32'd1);
        chk("sel1_out_data3", {24'd0, out_data3}, 32'hB1);
        chk("sel1_out_ch3", {30'd0, out_ch3}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
